hilo_mult_unit: RTL and testbench

Multi-cycle multiply/accumulate unit with the architectural HI/LO register pair. It sits in EX directly downstream of the ALU controller and consumes its 5-bit ALUControl code for MULT, MULTU, MUL, MADD, MSUB, MTHI, MTLO, MFHI and MFLO. It raises Busy so the pipeline stalls while an iterative product is in flight.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/mult_core_seq.sv | 55 +++++
 rtl/hilo_mult_unit.sv | 168 ++++++++++++++++
 tb/tb_hilo_mult_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU controller and hilo_mult_unit.
//   - WIDTH: operand / HI / LO width (product is 2*WIDTH)
//   - ALU_*: 5-bit ALUControl codes decoded by the multiply unit
//   - state_t: multiply sequencer states
//   - is_signed_mul(): true for the multiply codes that use signed operands
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] ALU_MULT  = 5'b00011;
  localparam logic [4:0] ALU_MULTU = 5'b00100;
  localparam logic [4:0] ALU_MUL   = 5'b10011;
  localparam logic [4:0] ALU_MADD  = 5'b10100;
  localparam logic [4:0] ALU_MSUB  = 5'b10101;
  localparam logic [4:0] ALU_MFHI  = 5'b10111;
  localparam logic [4:0] ALU_MFLO  = 5'b11000;
  localparam logic [4:0] ALU_MTHI  = 5'b11001;
  localparam logic [4:0] ALU_MTLO  = 5'b11010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // MULTU is the only unsigned multiply; every other multiply code is signed.
  function automatic logic is_signed_mul(input logic [4:0] op);
    return (op != ALU_MULTU);
  endfunction

endpackage

// File: rtl/mult_core_seq.sv
// mult_core_seq: radix-2 shift-add multiplier over unsigned magnitudes.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : capture mag_a_i / mag_b_i and clear the partial product
//   step_i         : process one multiplier bit (W steps give the full product)
//   mag_a_i/mag_b_i: unsigned operand magnitudes
//   prod_o         : 2*W-bit unsigned product (valid after W steps)
module mult_core_seq #(
  parameter int W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   mag_a_i,
  input  logic [W-1:0]   mag_b_i,
  output logic [2*W-1:0] prod_o
);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   mplier_q, mplier_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (load_i) begin
      mcand_d  = {{W{1'b0}}, mag_a_i};
      mplier_d = mag_b_i;
      prod_d   = '0;
    end else if (step_i) begin
      // Multiplicand walks left while the multiplier is consumed LSB-first.
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: multi-cycle multiply / accumulate unit owning HI and LO.
//   Clk, Rst        : clock, asynchronous active-high reset
//   Start           : EX holds a valid instruction for this unit
//   ALUControl      : operation code from the ALU controller
//   A, B            : rs / rt operands
//   Busy            : registered, high while a multiply is in flight
//   Done            : registered one-cycle pulse after the commit edge
//   HI, LO          : architectural HI / LO
//   MulResult       : low word of the signed product of the last MUL
//   RdData          : HI when ALUControl is MFHI, otherwise LO
// Build option: define MADD_MSUB_EN to enable MADD/MSUB accumulation;
// without it those codes are ignored like any unrecognised code.
//
// state | meaning
// IDLE  | waiting for Start
// CALC  | one shift-add step per cycle, WIDTH cycles
// FINAL | sign correction, accumulate, commit
// DONE  | Done pulse; a new Start may be accepted here
module hilo_mult_unit
  import alu_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] MulResult,
  output logic [WIDTH-1:0] RdData
);

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mulres_q, mulres_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               is_mul_op;
  logic               signed_op;
  logic               load;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_u, prod_s;

  always_comb begin
    is_mul_op = 1'b0;
    case (ALUControl)
      ALU_MULT, ALU_MULTU, ALU_MUL: is_mul_op = 1'b1;
`ifdef MADD_MSUB_EN
      ALU_MADD, ALU_MSUB:           is_mul_op = 1'b1;
`endif
      default:                      is_mul_op = 1'b0;
    endcase
  end

  assign accept    = Start && ((state_q == IDLE) || (state_q == DONE));
  assign signed_op = is_signed_mul(ALUControl);
  assign load      = accept && is_mul_op;

  // The core works on magnitudes; the sign is restored in FINAL.
  assign mag_a = (signed_op && A[WIDTH-1]) ? -A : A;
  assign mag_b = (signed_op && B[WIDTH-1]) ? -B : B;

  mult_core_seq #(
    .W(WIDTH)
  ) u_core (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .load_i (load),
    .step_i (state_q == CALC),
    .mag_a_i(mag_a),
    .mag_b_i(mag_b),
    .prod_o (prod_u)
  );

  assign prod_s = neg_q ? -prod_u : prod_u;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mulres_d = mulres_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (is_mul_op) begin
            state_d = CALC;
            cnt_d   = 6'(WIDTH - 1);
            op_d    = ALUControl;
            neg_d   = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
          end else if (ALUControl == ALU_MTHI) begin
            hi_d = A;
          end else if (ALUControl == ALU_MTLO) begin
            lo_d = A;
          end
        end
      end
      CALC: begin
        // Down-counter: the step taken while cnt_q is 0 is the last one.
        if (cnt_q == 6'd0) begin
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      FINAL: begin
        state_d = DONE;
        case (op_q)
          ALU_MULT, ALU_MULTU: {hi_d, lo_d} = prod_s;
          ALU_MUL:             mulres_d = prod_s[WIDTH-1:0];
`ifdef MADD_MSUB_EN
          ALU_MADD:            {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          ALU_MSUB:            {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == CALC) || (state_d == FINAL);
  assign done_d = (state_d == DONE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mulres_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mulres_q <= mulres_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign MulResult = mulres_q;
  assign RdData    = (ALUControl == ALU_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Testbench for hilo_mult_unit: directed test-plan cases followed by random
// operations, all checked against a 64-bit arithmetic model of HI/LO/MulResult.
module tb_hilo_mult_unit;

  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MUL   = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_MFHI  = 5'b10111;
  localparam logic [4:0] OP_MFLO  = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [4:0]  ALUControl;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] HI, LO, MulResult, RdData;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_hi = '0, m_lo = '0, m_mul = '0;

  hilo_mult_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .ALUControl(ALUControl),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .HI        (HI),
    .LO        (LO),
    .MulResult (MulResult),
    .RdData    (RdData)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sprod(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] uprod(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, HI, m_hi);
    check({tag, "_lo"}, LO, m_lo);
    check({tag, "_mulres"}, MulResult, m_mul);
  endtask

  // Issues a multiply at the current negedge and returns at the negedge where
  // Done is high. With hammer set, Start(MULT) is re-driven mid-flight.
  task automatic do_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hammer);
    int lat = 0;
    int busy_cyc = 0;
    logic [63:0] acc;
    Start = 1'b1; ALUControl = op; A = a; B = b;
    acc = {m_hi, m_lo};
    case (op)
      OP_MULT:  {m_hi, m_lo} = sprod(a, b);
      OP_MULTU: {m_hi, m_lo} = uprod(a, b);
      OP_MUL:   m_mul = sprod(a, b) & 64'hFFFF_FFFF;
      OP_MADD:  {m_hi, m_lo} = acc + sprod(a, b);
      OP_MSUB:  {m_hi, m_lo} = acc - sprod(a, b);
      default: ;
    endcase
    @(negedge Clk);
    Start = 1'b0;
    while (!Done && lat < 100) begin
      if (Busy) busy_cyc++;
      if (hammer && lat >= 5 && lat < 20) begin
        Start = 1'b1; ALUControl = OP_MULT;
      end else begin
        Start = 1'b0;
      end
      A = $urandom; B = $urandom;
      @(negedge Clk);
      lat++;
    end
    Start = 1'b0;
    check("mul_latency", 64'(lat), 64'd33);
    check("mul_busy_cycles", 64'(busy_cyc), 64'd33);
    check("busy_low_in_done", Busy, 1'b0);
    check_regs("mul_commit");
  endtask

  task automatic do_move(input logic [4:0] op, input logic [31:0] a);
    Start = 1'b1; ALUControl = op; A = a; B = $urandom;
    if (op == OP_MTHI) m_hi = a; else m_lo = a;
    @(negedge Clk);
    Start = 1'b0;
    check("move_busy", Busy, 1'b0);
    check("move_done", Done, 1'b0);
    check_regs("move");
  endtask

  task automatic do_ignored(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; ALUControl = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    check("ign_busy", Busy, 1'b0);
    check("ign_done", Done, 1'b0);
    check("ign_rddata", RdData, (op == OP_MFHI) ? m_hi : m_lo);
    check_regs("ign");
  endtask

  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_MTHI, OP_MTLO:         do_move(op, a);
      OP_MULT, OP_MULTU, OP_MUL: do_mul(op, a, b, 1'b0);
`ifdef MADD_MSUB_EN
      OP_MADD, OP_MSUB:         do_mul(op, a, b, 1'b0);
`endif
      default:                  do_ignored(op, a, b);
    endcase
  endtask

  initial begin
    int dones;
    int busies;
    logic [4:0] ops [10];
    logic [4:0] op;
    ops = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB,
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 5'b00000};

    Rst = 1'b1; Start = 1'b0; ALUControl = '0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_rddata", RdData, 32'd0);
    check_regs("rst");
    Rst = 1'b0;
    @(negedge Clk);

    // Signed MULT with a negative operand.
    do_mul(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("plan_mult_hi", HI, 32'hFFFF_FFFF);
    check("plan_mult_lo", LO, 32'hFFFF_FFFA);
    @(negedge Clk);
    check("done_one_cycle", Done, 1'b0);

    do_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("plan_multu_hi", HI, 32'hFFFF_FFFE);
    check("plan_multu_lo", LO, 32'h0000_0001);
    // MTHI in DONE keeps the freshly committed LO.
    do_move(OP_MTHI, 32'd0);
    do_move(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MADD_MSUB_EN
    do_mul(OP_MADD, 32'd1, 32'd1, 1'b0);
    check("plan_madd_hi", HI, 32'h0000_0001);
    check("plan_madd_lo", LO, 32'h0000_0000);
    do_mul(OP_MSUB, 32'd1, 32'd2, 1'b0);
    check("plan_msub_hi", HI, 32'h0000_0000);
    check("plan_msub_lo", LO, 32'hFFFF_FFFE);
`else
    do_ignored(OP_MADD, 32'd1, 32'd1);
    do_ignored(OP_MSUB, 32'd1, 32'd2);
    check("plan_madd_off_lo", LO, 32'hFFFF_FFFF);
`endif

    do_move(OP_MTHI, 32'hAAAA_5555);
    do_move(OP_MTLO, 32'hAAAA_5555);
    do_mul(OP_MUL, 32'd2, 32'd3, 1'b0);
    check("plan_mul_res", MulResult, 32'd6);
    check("plan_mul_hi", HI, 32'hAAAA_5555);
    @(negedge Clk);
    ALUControl = OP_MFHI;
    #1 check("plan_mfhi", RdData, 32'hAAAA_5555);
    ALUControl = OP_MFLO;
    #1 check("plan_mflo", RdData, m_lo);

    // Reset mid-calculation aborts without commit.
    @(negedge Clk);
    Start = 1'b1; ALUControl = OP_MULT; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    check("abort_busy_before", Busy, 1'b1);
    #1 Rst = 1'b1;
    #1;
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    m_hi = '0; m_lo = '0; m_mul = '0;
    check_regs("abort");
    @(negedge Clk);
    Rst = 1'b0;
    dones = 0; busies = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) dones++;
      if (Busy) busies++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_no_busy", 64'(busies), 64'd0);
    do_mul(OP_MULTU, 32'd4, 32'd5, 1'b0);
    check("plan_after_abort_lo", LO, 32'd20);

    // Back-to-back accept in DONE, then Start re-driven during Busy.
    do_mul(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_mul(OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    dones = 0; busies = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) dones++;
      if (Busy) busies++;
    end
    check("hammer_extra_done", 64'(dones), 64'd0);
    check("hammer_extra_busy", 64'(busies), 64'd0);
    check_regs("hammer_final");

    // Random operations, sometimes issued in DONE, sometimes after an idle gap.
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 9)];
      if (op == 5'b00000) op = 5'($urandom);
      apply(op, $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge Clk);
        check("rand_idle_done", Done, 1'b0);
      end
    end
    @(negedge Clk);
    check_regs("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
